// File: rtl/fp_normalize_pack.sv
// rtl/fp_normalize_pack.sv - post-add normalise/pack stage of the 8-bit-mantissa FP adder
// Shifts the raw sum one bit per cycle until the hidden one is restored, then packs {sign,exp,frac}.
module fp_normalize_pack #(
  parameter int EW = 4,
  parameter int MW = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EW-1:0]    in_exp,
  input  logic [MW+1:0]    in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   out_res,
  output logic             out_ovf,
  output logic             out_unf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [EW-1:0] EMAX = '1;

  state_t          state_q, state_d;
  logic [MW+1:0]   m_q, m_d;
  logic [EW-1:0]   e_q, e_d;
  logic            s_q, s_d;
  logic [EW+MW:0]  res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            vld_q, vld_d;

  logic [EW:0]     e_inc;
  logic [MW+1:0]   m_shr;

  // One extra bit on the increment so an all-ones input exponent cannot wrap past the overflow check.
  assign e_inc = {1'b0, e_q} + (EW+1)'(1);
  assign m_shr = m_q >> 1;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    s_d     = s_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_sign;
          e_d     = in_exp;
          m_d     = in_mant;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (m_q == '0) begin
          res_d   = {s_q, {EW{1'b0}}, {MW{1'b0}}};
          state_d = DONE;
        end else if (m_q[MW+1]) begin
          m_d = m_shr;
          e_d = e_inc[EW-1:0];
          if (e_inc >= {1'b0, EMAX}) begin
            ovf_d = 1'b1;
            res_d = {s_q, EMAX, {MW{1'b0}}};
          end else begin
            res_d = {s_q, e_inc[EW-1:0], m_shr[MW-1:0]};
          end
          state_d = DONE;
        end else if (m_q[MW]) begin
          res_d   = {s_q, e_q, m_q[MW-1:0]};
          state_d = DONE;
        end else if (e_q <= EW'(1)) begin
          unf_d   = 1'b1;
          res_d   = {s_q, {EW{1'b0}}, {MW{1'b0}}};
          state_d = DONE;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - EW'(1);
        end
      end
      DONE: begin
        // First DONE cycle publishes the packed word; handshake only once it is visible.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      s_q     <= s_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb/tb_fp_normalize_pack.sv - self-checking bench for fp_normalize_pack
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [3:0]  in_exp;
  logic [8:0]  in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_res;
  logic        out_ovf;
  logic        out_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_normalize_pack #(.EW(4), .MW(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  typedef struct {
    logic [11:0] res;
    bit          ovf;
    bit          unf;
    int          lat;
  } model_t;

  typedef struct {
    string name;
    bit    s;
    int    e;
    int    m;
    int    exp_e;
    int    exp_f;
    bit    ovf;
    bit    unf;
    int    lat;
  } vec_t;

  // Reference: locate the leading one, then decide how far the exponent allows shifting.
  function automatic model_t model(input bit s, input int e, input int m);
    model_t r;
    int p;
    int k;
    r.ovf = 0;
    r.unf = 0;
    r.lat = 2;
    if (m == 0) begin
      r.res = {s, 11'd0};
    end else if (m >= 256) begin
      if (e + 1 >= 15) begin
        r.ovf = 1;
        r.res = {s, 4'hF, 7'h00};
      end else begin
        r.res = {s, 4'(e + 1), 7'((m >> 1) & 127)};
      end
    end else begin
      p = 7;
      while (((m >> p) & 1) == 0) p--;
      k = 7 - p;
      if (k == 0 || k <= e - 1) begin
        r.res = {s, 4'(e - k), 7'((m << k) & 127)};
        r.lat = 2 + k;
      end else begin
        r.unf = 1;
        r.res = {s, 11'd0};
        r.lat = 2 + ((e > 1) ? e - 1 : 0);
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit s, input int e, input int m, input model_t x, input string nm);
    int cyc;
    chk({nm, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = 4'(e);
    in_mant  = 9'(m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(x.lat));
    chk({nm, "_res"}, 32'(out_res), 32'(x.res));
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(x.ovf));
    chk({nm, "_unf"}, 32'(out_unf), 32'(x.unf));
    chk({nm, "_in_ready_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({nm, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t   vecs[$];
    model_t x;
    int     s, e, m, cyc;
    logic [11:0] held;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_unf", 32'(out_unf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{"carry",      0,  5, 'h1C0,  6, 'h60, 0, 0, 2});
    vecs.push_back('{"normal",     1,  9, 'h0A5,  9, 'h25, 0, 0, 2});
    vecs.push_back('{"deep_shift", 0, 10, 'h001,  3, 'h00, 0, 0, 9});
    vecs.push_back('{"underflow",  1,  2, 'h010,  0, 'h00, 0, 1, 3});
    vecs.push_back('{"zero",       1,  7, 'h000,  0, 'h00, 0, 0, 2});
    vecs.push_back('{"overflow",   0, 14, 'h100, 15, 'h00, 1, 0, 2});
    vecs.push_back('{"exp0_small", 0,  0, 'h040,  0, 'h00, 0, 1, 2});
    vecs.push_back('{"exp15_cry",  1, 15, 'h1FF, 15, 'h00, 1, 0, 2});
    vecs.push_back('{"exp1_norm",  0,  1, 'h080,  1, 'h00, 0, 0, 2});

    foreach (vecs[i]) begin
      x.res = {vecs[i].s, 4'(vecs[i].exp_e), 7'(vecs[i].exp_f)};
      x.ovf = vecs[i].ovf;
      x.unf = vecs[i].unf;
      x.lat = vecs[i].lat;
      run_op(vecs[i].s, vecs[i].e, vecs[i].m, x, vecs[i].name);
    end

    // Stalled output: result stays put and a new request is ignored while busy.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 4'd9; in_mant = 9'h0A5;
    @(posedge clk); #1;
    in_sign = 1'b1; in_exp = 4'd3; in_mant = 9'h1FF;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    held = out_res;
    chk("stall_first_res", 32'(held), 32'h4A5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_res_stable", 32'(out_res), 32'(held));
      chk("stall_valid_held", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release", 32'(out_valid), 32'd0);
    chk("stall_back_idle", 32'(in_ready), 32'd1);

    // Reset in the middle of a long shift drops the operation.
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 4'd10; in_mant = 9'h001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_res", 32'(out_res), 32'd0);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) cyc++;
    end
    chk("midrst_nothing_emitted", 32'(cyc), 32'd0);

    for (int i = 0; i < 300; i++) begin
      s = $urandom_range(0, 1);
      e = $urandom_range(0, 15);
      m = $urandom_range(0, 511) >> $urandom_range(0, 9);
      x = model(s[0], e, m);
      run_op(s[0], e, m, x, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
